// File: rtl/pipe_share_scheduler.sv
`default_nettype none
// ============================================================================
// pipe_share_scheduler
// Round-robin issue of NREQ requesters into one fixed-latency shared pipeline.
// Revision: 1.0
// ============================================================================
module pipe_share_scheduler #(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int LAT     = 10,
  parameter int MAX_OUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic                  pause,
  output logic [NREQ-1:0]       gnt,
  output logic                  pipe_in_valid,
  output logic [WIDTH-1:0]      pipe_in_data,
  input  logic                  pipe_out_valid,
  input  logic [WIDTH-1:0]      pipe_out_data,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  busy,
  output logic                  err
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(MAX_OUT + 1);

  logic [CW-1:0]  inflight [NREQ];
  logic [IDW-1:0] last_gnt;
  logic [NREQ-1:0] eligible;
  logic           grant_any;
  logic [IDW-1:0] grant_id;
  logic [WIDTH-1:0] winner_data;

  // Tag pipeline: stage LAT lines up with pipe_out_valid of the same operation
  logic [LAT:0]   tag_v;
  logic [IDW-1:0] tag_id [LAT+1];

  logic rsp_fire;
  logic mismatch;
  logic any_inflight;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = req[i] && (inflight[i] < CW'(MAX_OUT)) && !pause && !rst;
    end
  end

  always_comb begin
    gnt       = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!grant_any && eligible[(int'(last_gnt) + k) % NREQ]) begin
        grant_any = 1'b1;
        grant_id  = IDW'((int'(last_gnt) + k) % NREQ);
      end
    end
    if (grant_any) gnt[grant_id] = 1'b1;
  end

  always_comb begin
    winner_data = req_data[int'(grant_id)*WIDTH +: WIDTH];
  end

  always_comb begin
    rsp_fire = pipe_out_valid && tag_v[LAT];
    mismatch = pipe_out_valid != tag_v[LAT];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt      <= IDW'(NREQ - 1);
      pipe_in_valid <= 1'b0;
      pipe_in_data  <= '0;
      rsp_valid     <= '0;
      rsp_data      <= '0;
      err           <= 1'b0;
      tag_v         <= '0;
      for (int k = 0; k <= LAT; k++) tag_id[k] <= '0;
      for (int i = 0; i < NREQ; i++) inflight[i] <= '0;
    end else begin
      pipe_in_valid <= grant_any;
      if (grant_any) begin
        pipe_in_data <= winner_data;
        last_gnt     <= grant_id;
      end

      tag_v[0]  <= grant_any;
      tag_id[0] <= grant_id;
      for (int k = 1; k <= LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end

      rsp_valid <= '0;
      if (rsp_fire) begin
        rsp_valid[tag_id[LAT]] <= 1'b1;
        rsp_data               <= pipe_out_data;
      end
      if (mismatch) err <= 1'b1;

      // A simultaneous grant and response on one requester cancel out
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i] && !(rsp_fire && tag_id[LAT] == IDW'(i))) begin
          inflight[i] <= inflight[i] + CW'(1);
        end else if (!gnt[i] && rsp_fire && tag_id[LAT] == IDW'(i)) begin
          inflight[i] <= inflight[i] - CW'(1);
        end
      end
    end
  end

  always_comb begin
    any_inflight = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (inflight[i] != '0) any_inflight = 1'b1;
    end
    busy = pipe_in_valid || (|tag_v) || any_inflight;
  end

endmodule
`default_nettype wire
